store_buffer: RTL and testbench

- Write-side counterpart to the core's lw path: accepts sb/sh/sw requests from execute, queues them in a small in-order FIFO, and drains them one per handshake into data_memory's write port.
- Sits between the ALU result/rs2_data and data_memory.
- Lets execute retire stores without waiting on memory.
- Provides a drain/halt handshake so the CPU stops only after every committed store has reached memory.

---
 rtl/store_buffer_pkg.sv | 23 ++
 rtl/store_lane_align.sv | 43 ++++
 rtl/store_buffer.sv | 166 ++++++++++++++++
 tb/tb_store_buffer.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// Shared store-path types and constants for the store buffer.
// Optional store-to-load forwarding is enabled with STORE_BUFFER_FORWARD_EN.
package store_buffer_pkg;

    localparam logic [6:0] OPCODE_STORE = 7'b0100011;
    localparam logic [2:0] FUNC3_SB     = 3'b000;
    localparam logic [2:0] FUNC3_SH     = 3'b001;
    localparam logic [2:0] FUNC3_SW     = 3'b010;
    localparam int         STORE_ADDR_W = 32;

    typedef struct packed {
        logic [STORE_ADDR_W-1:2] word_addr;
        logic [31:0]             data;
        logic [3:0]              byte_en;
    } store_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        DONE
    } drain_state_t;

endpackage

// File: rtl/store_lane_align.sv
// Byte-lane steering for sb/sh/sw: produces lane enables and replicated data.
// Flags misaligned accesses and unsupported func3 encodings.
module store_lane_align
    import store_buffer_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic [1:0]  offset,
    input  logic [31:0] data,
    output logic [3:0]  byte_en,
    output logic [31:0] aligned_data,
    output logic        error
);

    always_comb begin
        byte_en      = '0;
        aligned_data = '0;
        error        = 1'b0;
        unique case (1'b1)
            (func3 == FUNC3_SB): begin
                byte_en      = 4'b0001 << offset;
                aligned_data = {4{data[7:0]}};
            end
            (func3 == FUNC3_SH): begin
                if (offset[0]) begin
                    error = 1'b1;
                end else begin
                    byte_en      = 4'b0011 << offset;
                    aligned_data = {2{data[15:0]}};
                end
            end
            (func3 == FUNC3_SW): begin
                if (offset != 2'b00) begin
                    error = 1'b1;
                end else begin
                    byte_en      = 4'b1111;
                    aligned_data = data;
                end
            end
            default: error = 1'b1;
        endcase
    end

endmodule

// File: rtl/store_buffer.sv
// In-order store FIFO between execute and data_memory with drain handshake.
// Define STORE_BUFFER_FORWARD_EN to add combinational store-to-load forwarding.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         store_valid,
    output logic                         store_ready,
    input  logic [ADDR_W-1:0]            store_address,
    input  logic [31:0]                  store_data,
    input  logic [2:0]                   store_func3,
    output logic                         store_error,
    output logic                         memory_we,
    output logic [ADDR_W-1:0]            memory_address,
    output logic [31:0]                  memory_write_data,
    output logic [3:0]                   memory_byte_en,
    input  logic                         memory_ready,
    input  logic                         drain_request,
    output logic                         drained,
    output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef STORE_BUFFER_FORWARD_EN
    ,
    input  logic [ADDR_W-1:0]            load_address,
    output logic                         load_hit,
    output logic [31:0]                  load_forward_data
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef struct packed {
        logic [ADDR_W-1:2] word_addr;
        logic [31:0]       data;
        logic [3:0]        byte_en;
    } entry_t;

    entry_t        fifo_q [DEPTH];
    entry_t        head;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          err_q;
    logic [3:0]    al_be;
    logic [31:0]   al_data;
    logic          al_err;
    logic          accept;
    logic          push;
    logic          pop;
    drain_state_t  state_q;
    drain_state_t  state_d;

    store_lane_align u_align (
        .func3        (store_func3),
        .offset       (store_address[1:0]),
        .data         (store_data),
        .byte_en      (al_be),
        .aligned_data (al_data),
        .error        (al_err)
    );

    // Ready never depends on memory_ready: a full buffer stalls even while popping.
    assign store_ready = (count_q != CW'(DEPTH)) && !drain_request && !reset;
    assign accept      = store_valid && store_ready;
    assign push        = accept && !al_err;
    assign pop         = memory_we && memory_ready;

    assign head              = fifo_q[rd_ptr];
    assign memory_we         = (count_q != '0);
    assign memory_address    = memory_we ? {head.word_addr, 2'b00} : '0;
    assign memory_write_data = memory_we ? head.data : '0;
    assign memory_byte_en    = memory_we ? head.byte_en : '0;
    assign store_error       = err_q;
    assign count             = count_q;
    assign drained           = (state_q == DONE);

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            err_q <= accept && al_err;
            if (push) begin
                fifo_q[wr_ptr] <= '{word_addr: store_address[ADDR_W-1:2],
                                    data:      al_data,
                                    byte_en:   al_be};
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (drain_request) state_d = FLUSH;
            end
            FLUSH: begin
                if (!drain_request) begin
                    state_d = IDLE;
                end else if (count_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!drain_request) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef STORE_BUFFER_FORWARD_EN
    logic [3:0]    fwd_mask;
    logic [PW-1:0] fwd_idx;
    logic          load_off_unused;

    assign load_off_unused = ^load_address[1:0];

    // Walk oldest to youngest so younger matching lanes overwrite older ones.
    always_comb begin
        fwd_mask          = '0;
        fwd_idx           = '0;
        load_forward_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = rd_ptr + PW'(i);
            if ((CW'(i) < count_q) &&
                (fifo_q[fwd_idx].word_addr == load_address[ADDR_W-1:2])) begin
                for (int b = 0; b < 4; b++) begin
                    if (fifo_q[fwd_idx].byte_en[b]) begin
                        load_forward_data[b*8 +: 8] = fifo_q[fwd_idx].data[b*8 +: 8];
                        fwd_mask[b] = 1'b1;
                    end
                end
            end
        end
    end

    assign load_hit = (fwd_mask == 4'hF);
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: stimulus queues expected writes,
// a negedge monitor pops and compares each memory write handshake.
module tb_store_buffer;

    logic        clock = 1'b0;
    logic        reset;
    logic        store_valid;
    logic        store_ready;
    logic [31:0] store_address;
    logic [31:0] store_data;
    logic [2:0]  store_func3;
    logic        store_error;
    logic        memory_we;
    logic [31:0] memory_address;
    logic [31:0] memory_write_data;
    logic [3:0]  memory_byte_en;
    logic        memory_ready;
    logic        drain_request;
    logic        drained;
    logic [2:0]  count;
`ifdef STORE_BUFFER_FORWARD_EN
    logic [31:0] load_address;
    logic        load_hit;
    logic [31:0] load_forward_data;
`endif

    always #5 clock = ~clock;

    store_buffer #(.DEPTH(4), .ADDR_W(32)) dut (
        .clock             (clock),
        .reset             (reset),
        .store_valid       (store_valid),
        .store_ready       (store_ready),
        .store_address     (store_address),
        .store_data        (store_data),
        .store_func3       (store_func3),
        .store_error       (store_error),
        .memory_we         (memory_we),
        .memory_address    (memory_address),
        .memory_write_data (memory_write_data),
        .memory_byte_en    (memory_byte_en),
        .memory_ready      (memory_ready),
        .drain_request     (drain_request),
        .drained           (drained),
        .count             (count)
`ifdef STORE_BUFFER_FORWARD_EN
        ,
        .load_address      (load_address),
        .load_hit          (load_hit),
        .load_forward_data (load_forward_data)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (memory_we === 1'b1 && memory_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr %h expected none",
                         memory_address);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", memory_address, mon_e.addr);
                check("wr_data", memory_write_data, mon_e.data);
                check("wr_be", {28'd0, memory_byte_en}, {28'd0, mon_e.be});
            end
        end
    end

    task automatic push(input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] f3, input bit legal,
                        input logic [31:0] ea, input logic [31:0] ed,
                        input logic [3:0] eb);
        int n = 0;
        store_valid   = 1'b1;
        store_address = a;
        store_data    = d;
        store_func3   = f3;
        @(negedge clock);
        while (store_ready !== 1'b1 && n < 50) begin
            n++;
            @(negedge clock);
        end
        if (store_ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL push_timeout: got store_ready=0 expected 1");
        end else if (legal) begin
            exp_q.push_back('{addr: ea, data: ed, be: eb});
        end
        @(posedge clock);
        #1;
        store_valid = 1'b0;
    endtask

    task automatic wait_empty();
        int n = 0;
        @(negedge clock);
        while (count != 0 && n < 50) begin
            n++;
            @(negedge clock);
        end
        check("wait_empty", {29'd0, count}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset         = 1'b1;
        store_valid   = 1'b0;
        store_address = '0;
        store_data    = '0;
        store_func3   = '0;
        memory_ready  = 1'b0;
        drain_request = 1'b0;
`ifdef STORE_BUFFER_FORWARD_EN
        load_address  = '0;
`endif
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_count", {29'd0, count}, 32'd0);
        check("rst_we", {31'd0, memory_we}, 32'd0);
        check("rst_addr", memory_address, 32'd0);
        check("rst_data", memory_write_data, 32'd0);
        check("rst_be", {28'd0, memory_byte_en}, 32'd0);
        check("rst_err", {31'd0, store_error}, 32'd0);
        check("rst_drained", {31'd0, drained}, 32'd0);
        check("rst_ready", {31'd0, store_ready}, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("ready_after_rst", {31'd0, store_ready}, 32'd1);

        // single sw, immediate drain
        @(posedge clock);
        #1;
        memory_ready = 1'b1;
        push(32'h10, 32'hDEADBEEF, 3'b010, 1, 32'h10, 32'hDEADBEEF, 4'hF);
        @(negedge clock);
        check("sw_count1", {29'd0, count}, 32'd1);
        check("sw_we", {31'd0, memory_we}, 32'd1);
        @(negedge clock);
        check("sw_count0", {29'd0, count}, 32'd0);

        // byte and halfword lane steering
        @(posedge clock);
        #1;
        push(32'h13, 32'h000000AB, 3'b000, 1, 32'h10, 32'hABABABAB, 4'b1000);
        push(32'h16, 32'h00001234, 3'b001, 1, 32'h14, 32'h12341234, 4'b1100);
        wait_empty();

        // fill to DEPTH with memory stalled
        @(posedge clock);
        #1;
        memory_ready = 1'b0;
        push(32'h100, 32'h00000001, 3'b010, 1, 32'h100, 32'h00000001, 4'hF);
        push(32'h104, 32'h00000002, 3'b010, 1, 32'h104, 32'h00000002, 4'hF);
        push(32'h109, 32'h000000C3, 3'b000, 1, 32'h108, 32'hC3C3C3C3, 4'b0010);
        push(32'h10C, 32'h0000BEEF, 3'b001, 1, 32'h10C, 32'hBEEFBEEF, 4'b0011);
        @(negedge clock);
        check("full_count", {29'd0, count}, 32'd4);
        check("full_ready", {31'd0, store_ready}, 32'd0);
        @(posedge clock);
        #1;
        memory_ready = 1'b1;
        wait_empty();

        // misaligned sw and illegal func3
        @(posedge clock);
        #1;
        push(32'h12, 32'h55555555, 3'b010, 0, 0, 0, 0);
        @(negedge clock);
        check("mis_err", {31'd0, store_error}, 32'd1);
        check("mis_count", {29'd0, count}, 32'd0);
        check("mis_we", {31'd0, memory_we}, 32'd0);
        @(negedge clock);
        check("mis_err_pulse", {31'd0, store_error}, 32'd0);
        @(posedge clock);
        #1;
        push(32'h20, 32'h66666666, 3'b011, 0, 0, 0, 0);
        @(negedge clock);
        check("f3_err", {31'd0, store_error}, 32'd1);
        check("f3_count", {29'd0, count}, 32'd0);
        check("f3_we", {31'd0, memory_we}, 32'd0);
        @(negedge clock);
        check("f3_err_pulse", {31'd0, store_error}, 32'd0);

        // drain handshake
        @(posedge clock);
        #1;
        memory_ready = 1'b0;
        push(32'h200, 32'hAAAA0001, 3'b010, 1, 32'h200, 32'hAAAA0001, 4'hF);
        push(32'h204, 32'h0000BEEF, 3'b001, 1, 32'h204, 32'hBEEFBEEF, 4'b0011);
        drain_request = 1'b1;
        @(negedge clock);
        check("drain_ready", {31'd0, store_ready}, 32'd0);
        check("drain_count", {29'd0, count}, 32'd2);
        check("drain_early", {31'd0, drained}, 32'd0);
        @(posedge clock);
        #1;
        memory_ready = 1'b1;
        n = 0;
        @(negedge clock);
        while (count != 0 && n < 20) begin
            n++;
            @(negedge clock);
        end
        check("drain_empty", {29'd0, count}, 32'd0);
        check("drained_lag", {31'd0, drained}, 32'd0);
        @(negedge clock);
        check("drained_set", {31'd0, drained}, 32'd1);
        @(posedge clock);
        #1;
        drain_request = 1'b0;
        @(negedge clock);
        check("undrain_ready", {31'd0, store_ready}, 32'd1);
        @(negedge clock);
        check("drained_clr", {31'd0, drained}, 32'd0);

        // reset during flush discards queued stores
        @(posedge clock);
        #1;
        memory_ready = 1'b0;
        push(32'h300, 32'h12345678, 3'b010, 1, 32'h300, 32'h12345678, 4'hF);
        push(32'h304, 32'h87654321, 3'b010, 1, 32'h304, 32'h87654321, 4'hF);
        drain_request = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b1;
        exp_q.delete();
        @(posedge clock);
        #1;
        reset         = 1'b0;
        drain_request = 1'b0;
        @(negedge clock);
        check("midrst_count", {29'd0, count}, 32'd0);
        check("midrst_we", {31'd0, memory_we}, 32'd0);
        check("midrst_addr", memory_address, 32'd0);
        check("midrst_drained", {31'd0, drained}, 32'd0);
        memory_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("midrst_nowrite", {31'd0, memory_we}, 32'd0);
        end

`ifdef STORE_BUFFER_FORWARD_EN
        @(posedge clock);
        #1;
        memory_ready = 1'b0;
        push(32'h20, 32'h11223344, 3'b010, 1, 32'h20, 32'h11223344, 4'hF);
        push(32'h21, 32'h000000FF, 3'b000, 1, 32'h20, 32'hFFFFFFFF, 4'b0010);
        load_address = 32'h20;
        @(negedge clock);
        check("fwd_hit", {31'd0, load_hit}, 32'd1);
        check("fwd_data", load_forward_data, 32'h1122FF44);
        @(posedge clock);
        #1;
        memory_ready = 1'b1;
        wait_empty();
        @(posedge clock);
        #1;
        memory_ready = 1'b0;
        push(32'h24, 32'h00000077, 3'b000, 1, 32'h24, 32'h77777777, 4'b0001);
        load_address = 32'h24;
        @(negedge clock);
        check("fwd_partial", {31'd0, load_hit}, 32'd0);
        @(posedge clock);
        #1;
        memory_ready = 1'b1;
        wait_empty();
`endif

        repeat (2) @(negedge clock);
        check("sb_leftover", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
